// File: rtl/alu_filter_iir_mc.sv
// Multi-channel cascaded biquad IIR filter time-sharing one external DSP48A1.
// Each stage issues five MACs, drains the DSP pipeline, then saturates and updates history.
module alu_filter_iir_mc #(
   parameter int NCH     = 2,
   parameter int NSTAGES = 2,
   parameter int DSP_LAT = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NSTAGES*90-1:0]     coefs_flat,
   input  logic signed [17:0]        sample_in,
   input  logic [2:0]                sample_in_ch,
   input  logic                      sample_in_rdy,
   input  logic                      clr,
   output logic signed [17:0]        sample_out,
   output logic [2:0]                sample_out_ch,
   output logic                      sample_out_rdy,
   output logic                      busy,
   output logic                      overrun,
   input  logic [83:0]               dsp_outs_flat,
   output logic [43:0]               dsp_ins_flat
);

   localparam logic [7:0] DSP_NOP      = 8'h00;
   localparam logic [7:0] DSP_XIN_MULT = 8'h01;
   localparam logic [7:0] DSP_ZIN_ZERO = 8'h00;
   localparam logic [7:0] DSP_ZIN_POUT = 8'h08;
   localparam int NREG = NCH * NSTAGES;
   localparam int SW   = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
   localparam int RW   = (NREG > 1) ? $clog2(NREG) : 1;

   typedef enum logic [2:0] {IDLE, MAC, DRAIN, WB, OUT} state_t;

   state_t                state_q, state_d;
   logic [SW-1:0]         stage_q, stage_d;
   logic [2:0]            tap_q, tap_d;
   logic [3:0]            dcnt_q, dcnt_d;
   logic [2:0]            ch_q, ch_d;
   logic signed [17:0]    x_q, x_d;
   logic signed [17:0]    x1_q [NREG];
   logic signed [17:0]    x1_d [NREG];
   logic signed [17:0]    x2_q [NREG];
   logic signed [17:0]    x2_d [NREG];
   logic signed [17:0]    y1_q [NREG];
   logic signed [17:0]    y1_d [NREG];
   logic signed [17:0]    y2_q [NREG];
   logic signed [17:0]    y2_d [NREG];
   logic [7:0]            opmode_q, opmode_d;
   logic signed [17:0]    a_q, a_d, b_q, b_d;
   logic signed [17:0]    out_q, out_d;
   logic [2:0]            out_ch_q, out_ch_d;
   logic                  out_rdy_q, out_rdy_d;
   logic                  busy_q, busy_d;
   logic                  overrun_q, overrun_d;

   logic signed [17:0]    coef [NSTAGES][5];
   logic signed [47:0]    p_in;
   logic [RW-1:0]         idx;
   logic signed [17:0]    operand, y_wb;
   logic                  idle, ch_ok;
   logic                  unused_dsp;

   function automatic logic signed [17:0] sat18(input logic signed [31:0] v);
      if (v > 32'sd131071)
         return 18'h1FFFF;
      else if (v < -32'sd131072)
         return 18'h20000;
      else
         return v[17:0];
   endfunction

   for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
      for (genvar k = 0; k < 5; k++) begin : g_tap
         assign coef[s][k] = coefs_flat[90*s+18*k +: 18];
      end
   end

   assign p_in       = dsp_outs_flat[47:0];
   assign unused_dsp = ^{dsp_outs_flat[83:48], dsp_outs_flat[15:0]};
   assign idx        = RW'(32'(ch_q) * NSTAGES + 32'(stage_q));
   assign idle       = (state_q == IDLE) && !busy_q;
   assign ch_ok      = 32'(sample_in_ch) < 32'(NCH);

   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      tap_d     = tap_q;
      dcnt_d    = dcnt_q;
      ch_d      = ch_q;
      x_d       = x_q;
      x1_d      = x1_q;
      x2_d      = x2_q;
      y1_d      = y1_q;
      y2_d      = y2_q;
      opmode_d  = DSP_NOP;
      a_d       = '0;
      b_d       = '0;
      out_d     = '0;
      out_ch_d  = '0;
      out_rdy_d = 1'b0;
      busy_d    = out_rdy_q ? 1'b0 : busy_q;
      overrun_d = sample_in_rdy && !(idle && ch_ok);
      y_wb      = sat18(p_in[47:16]);
      case (tap_q)
         3'd1:    operand = x1_q[idx];
         3'd2:    operand = x2_q[idx];
         3'd3:    operand = y1_q[idx];
         3'd4:    operand = y2_q[idx];
         default: operand = x_q;
      endcase

      case (state_q)
         IDLE: begin
            if (idle) begin
               // clear takes effect before a same-cycle strobe is accepted
               if (clr) begin
                  for (int i = 0; i < NREG; i++) begin
                     x1_d[i] = '0;
                     x2_d[i] = '0;
                     y1_d[i] = '0;
                     y2_d[i] = '0;
                  end
               end
               if (sample_in_rdy && ch_ok) begin
                  state_d = MAC;
                  stage_d = '0;
                  tap_d   = '0;
                  ch_d    = sample_in_ch;
                  x_d     = sample_in;
                  busy_d  = 1'b1;
               end
            end
         end
         MAC: begin
            opmode_d = (tap_q == 3'd0) ? (DSP_XIN_MULT | DSP_ZIN_ZERO)
                                       : (DSP_XIN_MULT | DSP_ZIN_POUT);
            a_d = coef[stage_q][tap_q];
            b_d = operand;
            if (tap_q == 3'd4) begin
               state_d = DRAIN;
               tap_d   = '0;
               dcnt_d  = '0;
            end else begin
               tap_d = tap_q + 3'd1;
            end
         end
         DRAIN: begin
            if (dcnt_q == 4'(DSP_LAT - 1))
               state_d = WB;
            else
               dcnt_d = dcnt_q + 4'd1;
         end
         WB: begin
            x2_d[idx] = x1_q[idx];
            x1_d[idx] = x_q;
            y2_d[idx] = y1_q[idx];
            y1_d[idx] = y_wb;
            x_d       = y_wb;
            if (stage_q == SW'(NSTAGES - 1)) begin
               state_d = OUT;
            end else begin
               stage_d = stage_q + SW'(1);
               state_d = MAC;
            end
         end
         OUT: begin
            out_d     = x_q;
            out_ch_d  = ch_q;
            out_rdy_d = 1'b1;
            stage_d   = '0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         stage_q   <= '0;
         tap_q     <= '0;
         dcnt_q    <= '0;
         ch_q      <= '0;
         x_q       <= '0;
         for (int i = 0; i < NREG; i++) begin
            x1_q[i] <= '0;
            x2_q[i] <= '0;
            y1_q[i] <= '0;
            y2_q[i] <= '0;
         end
         opmode_q  <= DSP_NOP;
         a_q       <= '0;
         b_q       <= '0;
         out_q     <= '0;
         out_ch_q  <= '0;
         out_rdy_q <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         stage_q   <= stage_d;
         tap_q     <= tap_d;
         dcnt_q    <= dcnt_d;
         ch_q      <= ch_d;
         x_q       <= x_d;
         x1_q      <= x1_d;
         x2_q      <= x2_d;
         y1_q      <= y1_d;
         y2_q      <= y2_d;
         opmode_q  <= opmode_d;
         a_q       <= a_d;
         b_q       <= b_d;
         out_q     <= out_d;
         out_ch_q  <= out_ch_d;
         out_rdy_q <= out_rdy_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign dsp_ins_flat   = {opmode_q, a_q, b_q};
   assign sample_out     = out_q;
   assign sample_out_ch  = out_ch_q;
   assign sample_out_rdy = out_rdy_q;
   assign busy           = busy_q;
   assign overrun        = overrun_q;

endmodule

// File: tb/tb_alu_filter_iir_mc.sv
// Bench for alu_filter_iir_mc: models the shared DSP48A1 and checks results
// against an arithmetic biquad-cascade reference with per-channel history.
module tb_alu_filter_iir_mc;
   localparam int NCH     = 2;
   localparam int NSTAGES = 2;
   localparam int DSP_LAT = 2;
   localparam int L       = 1 + NSTAGES * (6 + DSP_LAT);

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic [NSTAGES*90-1:0]  coefs_flat = '0;
   logic signed [17:0]     sample_in = '0;
   logic [2:0]             sample_in_ch = '0;
   logic                   sample_in_rdy = 1'b0;
   logic                   clr = 1'b0;
   logic signed [17:0]     sample_out;
   logic [2:0]             sample_out_ch;
   logic                   sample_out_rdy, busy, overrun;
   logic [83:0]            dsp_outs_flat;
   logic [43:0]            dsp_ins_flat;

   int cmp_n = 0;
   int fail_n = 0;
   int cf [NSTAGES][5];
   longint m_x1 [NCH][NSTAGES];
   longint m_x2 [NCH][NSTAGES];
   longint m_y1 [NCH][NSTAGES];
   longint m_y2 [NCH][NSTAGES];

   always #5 clk = ~clk;

   alu_filter_iir_mc #(.NCH(NCH), .NSTAGES(NSTAGES), .DSP_LAT(DSP_LAT)) dut (
      .clk(clk), .reset(reset), .coefs_flat(coefs_flat),
      .sample_in(sample_in), .sample_in_ch(sample_in_ch), .sample_in_rdy(sample_in_rdy),
      .clr(clr), .sample_out(sample_out), .sample_out_ch(sample_out_ch),
      .sample_out_rdy(sample_out_rdy), .busy(busy), .overrun(overrun),
      .dsp_outs_flat(dsp_outs_flat), .dsp_ins_flat(dsp_ins_flat));

   // DSP48A1 model: multiply, optional P feedback, result visible DSP_LAT edges after load
   logic [7:0]          d_op;
   logic signed [17:0]  d_a, d_b;
   logic signed [35:0]  d_m;
   logic signed [47:0]  d_p [DSP_LAT];
   assign d_op = dsp_ins_flat[43:36];
   assign d_a  = dsp_ins_flat[35:18];
   assign d_b  = dsp_ins_flat[17:0];
   assign d_m  = d_a * d_b;
   assign dsp_outs_flat = {d_m, d_p[DSP_LAT-1]};

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DSP_LAT; i++) d_p[i] <= '0;
      end else begin
         d_p[0] <= ((d_op[3:2] == 2'b10) ? d_p[0] : 48'sd0) +
                   ((d_op[1:0] == 2'b01) ? {{12{d_m[35]}}, d_m} : 48'd0);
         for (int i = 1; i < DSP_LAT; i++) d_p[i] <= d_p[i-1];
      end
   end

   function automatic void model_clear();
      for (int c = 0; c < NCH; c++)
         for (int s = 0; s < NSTAGES; s++) begin
            m_x1[c][s] = 0; m_x2[c][s] = 0; m_y1[c][s] = 0; m_y2[c][s] = 0;
         end
   endfunction

   function automatic int model_step(input int ch, input int x);
      longint xin, acc, y;
      xin = x;
      for (int s = 0; s < NSTAGES; s++) begin
         acc = longint'(cf[s][0]) * xin + longint'(cf[s][1]) * m_x1[ch][s] +
               longint'(cf[s][2]) * m_x2[ch][s] + longint'(cf[s][3]) * m_y1[ch][s] +
               longint'(cf[s][4]) * m_y2[ch][s];
         y = acc >>> 16;
         if (y > 131071) y = 131071;
         else if (y < -131072) y = -131072;
         m_x2[ch][s] = m_x1[ch][s];
         m_x1[ch][s] = xin;
         m_y2[ch][s] = m_y1[ch][s];
         m_y1[ch][s] = y;
         xin = y;
      end
      return int'(xin);
   endfunction

   task automatic set_stage(input int s, input int c0, input int c1, input int c2,
                            input int c3, input int c4);
      cf[s][0] = c0; cf[s][1] = c1; cf[s][2] = c2; cf[s][3] = c3; cf[s][4] = c4;
      for (int k = 0; k < 5; k++) coefs_flat[90*s+18*k +: 18] = 18'(cf[s][k]);
   endtask

   // Drives one strobe and waits (bounded) for the result; all calls start at posedge+1.
   task automatic send(input int ch, input int x, input bit with_clr,
                       output int got, output int gch, output int lat,
                       output int busy_bad, output int post_out);
      sample_in = 18'(x); sample_in_ch = 3'(ch); sample_in_rdy = 1'b1; clr = with_clr;
      @(posedge clk); #1;
      sample_in_rdy = 1'b0; clr = 1'b0;
      got = 0; gch = 0; lat = -1; busy_bad = 0; post_out = 0;
      if (busy !== 1'b1) busy_bad++;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (busy !== 1'b1) busy_bad++;
         if (sample_out_rdy === 1'b1) begin
            lat = i; got = int'(sample_out); gch = int'(sample_out_ch);
            break;
         end
      end
      @(posedge clk); #1;
      post_out = int'(sample_out) | int'(sample_out_ch);
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cmp_n++; if (sample_out !== 18'd0) begin fail_n++; $display("FAIL reset_out: got %0d want 0", sample_out); end
      cmp_n++; if (sample_out_ch !== 3'd0) begin fail_n++; $display("FAIL reset_out_ch: got %0d want 0", sample_out_ch); end
      cmp_n++; if (sample_out_rdy !== 1'b0) begin fail_n++; $display("FAIL reset_rdy: got %b want 0", sample_out_rdy); end
      cmp_n++; if (busy !== 1'b0) begin fail_n++; $display("FAIL reset_busy: got %b want 0", busy); end
      cmp_n++; if (overrun !== 1'b0) begin fail_n++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      cmp_n++; if (dsp_ins_flat !== 44'd0) begin fail_n++; $display("FAIL reset_dsp_ins: got %h want 0", dsp_ins_flat); end
      reset = 1'b0;
      begin
         int seen = 0;
         repeat (5) begin @(posedge clk); #1; if (sample_out_rdy !== 1'b0) seen++; end
         cmp_n++; if (seen != 0) begin fail_n++; $display("FAIL reset_no_rdy: got %0d strobes want 0", seen); end
      end
   endtask

   task automatic test_passthrough();
      int got, gch, lat, bb, po;
      set_stage(0, 32'h10000, 0, 0, 0, 0);
      set_stage(1, 32'h10000, 0, 0, 0, 0);
      send(0, 1000, 1'b1, got, gch, lat, bb, po);
      cmp_n++; if (got !== 1000) begin fail_n++; $display("FAIL pass_data: got %0d want 1000", got); end
      cmp_n++; if (gch !== 0) begin fail_n++; $display("FAIL pass_ch: got %0d want 0", gch); end
      cmp_n++; if (lat !== L) begin fail_n++; $display("FAIL pass_latency: got %0d want %0d", lat, L); end
      cmp_n++; if (bb !== 0) begin fail_n++; $display("FAIL pass_busy: got %0d low cycles want 0", bb); end
      cmp_n++; if (po !== 0) begin fail_n++; $display("FAIL pass_hold_zero: got %0d want 0", po); end
   endtask

   task automatic test_two_channel();
      int got, gch, lat, bb, po;
      int chs [3] = '{0, 1, 0};
      int xs  [3] = '{100, 500, 200};
      int exp [3] = '{100, 500, 300};
      set_stage(0, 32'h10000, 32'h10000, 0, 0, 0);
      set_stage(1, 32'h10000, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         send(chs[i], xs[i], i == 0, got, gch, lat, bb, po);
         cmp_n++; if (got !== exp[i] || gch !== chs[i]) begin
            fail_n++; $display("FAIL two_ch[%0d]: got %0d/ch%0d want %0d/ch%0d", i, got, gch, exp[i], chs[i]);
         end
      end
   endtask

   task automatic test_saturation();
      int got, gch, lat, bb, po;
      set_stage(0, 32'h1FFFF, 0, 0, 0, 0);
      set_stage(1, 32'h10000, 0, 0, 0, 0);
      send(0, 131071, 1'b1, got, gch, lat, bb, po);
      cmp_n++; if (got !== 131071) begin fail_n++; $display("FAIL sat_pos: got %0d want 131071", got); end
      send(1, -131072, 1'b0, got, gch, lat, bb, po);
      cmp_n++; if (got !== -131072) begin fail_n++; $display("FAIL sat_neg: got %0d want -131072", got); end
   endtask

   task automatic test_decay();
      int got, gch, lat, bb, po;
      int e1 [4] = '{1024, 512, 256, 128};
      int e2 [4] = '{1024, 1024, 768, 512};
      set_stage(0, 32'h10000, 0, 0, 32'h8000, 0);
      set_stage(1, 32'h10000, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         send(0, (i == 0) ? 1024 : 0, i == 0, got, gch, lat, bb, po);
         cmp_n++; if (got !== e1[i]) begin fail_n++; $display("FAIL decay1[%0d]: got %0d want %0d", i, got, e1[i]); end
      end
      set_stage(1, 32'h10000, 0, 0, 32'h8000, 0);
      for (int i = 0; i < 4; i++) begin
         send(1, (i == 0) ? 1024 : 0, i == 0, got, gch, lat, bb, po);
         cmp_n++; if (got !== e2[i]) begin fail_n++; $display("FAIL decay2[%0d]: got %0d want %0d", i, got, e2[i]); end
      end
   endtask

   task automatic test_drops();
      int got, gch, lat, bb, po, seen;
      set_stage(0, 32'h10000, 0, 0, 32'h8000, 0);
      set_stage(1, 32'h10000, 0, 0, 0, 0);
      clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
      sample_in = 18'sd1024; sample_in_ch = 3'd0; sample_in_rdy = 1'b1;
      @(posedge clk); #1;
      sample_in = 18'sd7777; sample_in_ch = 3'd1;
      @(posedge clk); #1;
      sample_in_rdy = 1'b0;
      cmp_n++; if (overrun !== 1'b1) begin fail_n++; $display("FAIL drop_busy_overrun: got %b want 1", overrun); end
      @(posedge clk); #1;
      cmp_n++; if (overrun !== 1'b0) begin fail_n++; $display("FAIL drop_overrun_pulse: got %b want 0", overrun); end
      clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
      lat = -1; got = 0; gch = 0;
      for (int i = 4; i <= 60; i++) begin
         @(posedge clk); #1;
         if (sample_out_rdy === 1'b1) begin lat = i; got = int'(sample_out); gch = int'(sample_out_ch); break; end
      end
      cmp_n++; if (got !== 1024 || gch !== 0 || lat !== L) begin
         fail_n++; $display("FAIL drop_inflight: got %0d/ch%0d lat %0d want 1024/ch0 lat %0d", got, gch, lat, L);
      end
      @(posedge clk); #1;
      sample_in = 18'sd999; sample_in_ch = 3'(NCH); sample_in_rdy = 1'b1;
      @(posedge clk); #1;
      sample_in_rdy = 1'b0;
      cmp_n++; if (overrun !== 1'b1 || busy !== 1'b0) begin
         fail_n++; $display("FAIL drop_bad_ch: got overrun %b busy %b want 1 0", overrun, busy);
      end
      seen = 0;
      repeat (L + 3) begin @(posedge clk); #1; if (sample_out_rdy !== 1'b0) seen++; end
      cmp_n++; if (seen != 0) begin fail_n++; $display("FAIL drop_bad_ch_out: got %0d strobes want 0", seen); end
      send(0, 0, 1'b0, got, gch, lat, bb, po);
      cmp_n++; if (got !== 512) begin fail_n++; $display("FAIL drop_history_ch0: got %0d want 512", got); end
      send(1, 0, 1'b0, got, gch, lat, bb, po);
      cmp_n++; if (got !== 0) begin fail_n++; $display("FAIL drop_history_ch1: got %0d want 0", got); end
   endtask

   task automatic test_clr_with_strobe();
      int got, gch, lat, bb, po;
      set_stage(0, 32'h10000, 0, 0, 32'h8000, 0);
      set_stage(1, 32'h10000, 0, 0, 0, 0);
      send(0, 1024, 1'b1, got, gch, lat, bb, po);
      send(0, 0, 1'b1, got, gch, lat, bb, po);
      cmp_n++; if (got !== 0) begin fail_n++; $display("FAIL clr_strobe: got %0d want 0", got); end
   endtask

   task automatic test_reset_mid_mac();
      int got, gch, lat, bb, po, seen;
      set_stage(0, 32'h10000, 0, 0, 32'h8000, 0);
      set_stage(1, 32'h10000, 0, 0, 0, 0);
      send(1, 1024, 1'b1, got, gch, lat, bb, po);
      sample_in = 18'sd0; sample_in_ch = 3'd1; sample_in_rdy = 1'b1;
      @(posedge clk); #1;
      sample_in_rdy = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1; #1;
      cmp_n++; if ({sample_out, sample_out_ch, sample_out_rdy, busy, overrun} !== 24'd0 || dsp_ins_flat !== 44'd0) begin
         fail_n++; $display("FAIL midreset_outs: got out %0d ch %0d rdy %b busy %b ovr %b ins %h want all 0",
                             sample_out, sample_out_ch, sample_out_rdy, busy, overrun, dsp_ins_flat);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 0;
      repeat (L + 5) begin @(posedge clk); #1; if (sample_out_rdy !== 1'b0) seen++; end
      cmp_n++; if (seen != 0) begin fail_n++; $display("FAIL midreset_no_rdy: got %0d strobes want 0", seen); end
      send(1, 1024, 1'b0, got, gch, lat, bb, po);
      cmp_n++; if (got !== 1024 || gch !== 1) begin
         fail_n++; $display("FAIL midreset_zero_hist: got %0d/ch%0d want 1024/ch1", got, gch);
      end
   endtask

   task automatic test_random();
      int got, gch, lat, bb, po, ch, x, exp;
      for (int s = 0; s < NSTAGES; s++)
         set_stage(s, int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 131071)) - 65536,
                   int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 65535)) - 32768,
                   int'($urandom_range(0, 32767)) - 16384);
      model_clear();
      for (int i = 0; i < 24; i++) begin
         ch = int'($urandom_range(0, NCH - 1));
         x  = (i % 6 == 5) ? ((i % 12 == 5) ? 131071 : -131072) : int'($urandom_range(0, 262143)) - 131072;
         exp = model_step(ch, x);
         send(ch, x, i == 0, got, gch, lat, bb, po);
         cmp_n++; if (got !== exp || gch !== ch || lat !== L) begin
            fail_n++; $display("FAIL random[%0d]: got %0d/ch%0d lat %0d want %0d/ch%0d lat %0d", i, got, gch, lat, exp, ch, L);
         end
      end
   endtask

   initial begin
      for (int s = 0; s < NSTAGES; s++) for (int k = 0; k < 5; k++) cf[s][k] = 0;
      model_clear();
      test_reset();
      test_passthrough();
      test_two_channel();
      test_saturation();
      test_decay();
      test_drops();
      test_clr_with_strobe();
      test_reset_mid_mac();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end

endmodule
